hdmi_clock_monitor: RTL and testbench
=====================================

// Module: hdmi_clock_monitor
// PURPOSE
// Supervises the HDMI input clock from the InternalClock domain. Counts transitions of a divided
// toggle from the HDMI clock domain over fixed gate windows, qualifies the rate against a window,
// sequences NO_CLOCK/ACQUIRE/LOCKED with hysteresis, and drives the board status LEDs.
// Capture datapath enables are gated on Locked.
// PARAMETERS
// GATE_CYCLES   1000000  gate window length in InternalClock cycles (>=2)
// CNT_W         24       width of edge counter / EdgeCount
// MIN_EDGES     1000     lowest edge count of a good window (inclusive)
// MAX_EDGES     2000     highest edge count of a good window (inclusive)
// LOCK_WINDOWS  4        consecutive good windows needed to reach LOCKED (>=1)
// LOSS_WINDOWS  2        consecutive bad windows in LOCKED that drop lock (>=1)
// PORTS
// InternalClock   in   1      sole clock
// Reset           in   1      synchronous, active-high
// Enable          in   1      monitor run; low forces IDLE
// ExternalToggle  in   1      asynchronous; toggled by HDMI-domain divider
// EdgeCount       out  CNT_W  edge count of last completed window
// CountValid      out  1      one-cycle pulse when EdgeCount updates
// Locked          out  1      high in LOCKED only
// State           out  2      IDLE=0, NO_CLOCK=1, ACQUIRE=2, LOCKED=3
// LED             out  2      [0]=Locked, [1]=acquire blink
// BEHAVIOUR
// - Interface: one clock InternalClock; Reset synchronous active-high; all outputs registered.
// - Reset: EdgeCount=0, CountValid=0, Locked=0, State=IDLE, LED=0, gate/edge/run counters=0,
//   synchroniser flops=0. Reset mid-operation aborts the window; no CountValid.
// - ExternalToggle -> 2-flop synchroniser -> 3rd flop; any transition = one edge. A toggle held
//   high through reset yields one edge after reset (accepted).
// - Edge counter saturates at 2^CNT_W-1; never wraps.
// - Gate counter runs 0..GATE_CYCLES-1 while Enable=1. Terminal cycle (gate==GATE_CYCLES-1): edge on
//   that cycle belongs to the closing window; at that clock edge EdgeCount<=count, CountValid<=1
//   (one cycle), edge counter <=0, gate <=0, FSM evaluates the window.
// - good = MIN_EDGES<=count<=MAX_EDGES. FSM transitions only at window end, except IDLE/Enable:
//   IDLE:     Enable=1 -> NO_CLOCK next cycle; gate/edge counters start from 0.
//   NO_CLOCK: good -> ACQUIRE (goodrun=1; LOCKED directly if LOCK_WINDOWS==1); bad -> stay.
//   ACQUIRE:  good -> goodrun+1; goodrun reaches LOCK_WINDOWS -> LOCKED; bad -> NO_CLOCK, goodrun=0.
//   LOCKED:   bad -> badrun+1; badrun reaches LOSS_WINDOWS -> NO_CLOCK; good -> badrun=0.
// - Enable=0 in any state -> IDLE next cycle; counters cleared, no CountValid, EdgeCount holds.
// - Locked and LED update on same edge as State. LED[1]: 0 in IDLE/NO_CLOCK, 1 in LOCKED,
//   toggles at each window end in ACQUIRE.
// - Reset has priority over Enable; Enable=0 has priority over a simultaneous window end.
// CONFIGURATION
// - HDMI_CLOCK_MONITOR_STICKY_EN defined: adds ports ClearLoss (in,1) and LossSticky (out,1, reset 0).
//   LossSticky set on LOCKED->NO_CLOCK; ClearLoss=1 clears it next cycle; set wins over clear on
//   same cycle; unaffected by Enable.
// - Undefined: both ports and sticky logic absent; all other behaviour identical.
// TESTING (GATE_CYCLES=100, MIN_EDGES=10, MAX_EDGES=14, LOCK_WINDOWS=3, LOSS_WINDOWS=2)
// - Reset, Enable=1, toggle every 8 cycles -> CountValid every 100 cycles, EdgeCount 12 or 13;
//   State 1->2 at window 1, 3 at window 3; Locked=1, LED=2'b11.
// - Locked, stop toggle -> EdgeCount=0 twice; State=1, Locked=0 after 2nd window;
//   LossSticky=1 until ClearLoss (macro on).
// - Toggle every 4 cycles -> EdgeCount=25 each window; State stays 1; Locked=0.
// - Locked, one window at 4 edges then good windows -> State stays 3 throughout.
// - Enable=0 at cycle 50 of window -> State=0 next cycle, no CountValid; Enable=1 -> first
//   CountValid exactly 101 cycles after Enable rises (1 cycle IDLE->NO_CLOCK + 100 gate).
// - Reset during ACQUIRE -> next cycle all outputs at reset values; toggle forced at 2^CNT_W
//   rate with CNT_W=4 -> EdgeCount saturates at 15.

Source files
------------

// File: rtl/hdmi_clock_monitor.sv
// -----------------------------------------------------------------------------
// hdmi_clock_monitor
//
// Purpose:
//   Supervises the HDMI input clock from the InternalClock domain. A divided
//   toggle produced in the HDMI clock domain (ExternalToggle) is synchronised,
//   and its transitions are counted over fixed gate windows of GATE_CYCLES
//   InternalClock cycles. Each completed window is qualified against
//   [MIN_EDGES, MAX_EDGES]. A hysteretic FSM walks IDLE / NO_CLOCK / ACQUIRE /
//   LOCKED and drives the board status LEDs. Downstream capture datapath
//   enables are expected to be gated on Locked.
//
// Optional feature macro:
//   HDMI_CLOCK_MONITOR_STICKY_EN - adds ClearLoss / LossSticky, a sticky flag
//   recording that lock was lost (LOCKED -> NO_CLOCK).
//
// Ports:
//   InternalClock  in   1      sole clock
//   Reset          in   1      synchronous, active-high
//   Enable         in   1      monitor run; low forces IDLE
//   ExternalToggle in   1      asynchronous toggle from the HDMI-domain divider
//   EdgeCount      out  CNT_W  edge count of last completed window
//   CountValid     out  1      one-cycle pulse when EdgeCount updates
//   Locked         out  1      high in LOCKED only
//   State          out  2      IDLE=0, NO_CLOCK=1, ACQUIRE=2, LOCKED=3 (FSM state)
//   LED            out  2      [0]=Locked, [1]=acquire blink
//   ClearLoss      in   1      (macro only) clears LossSticky
//   LossSticky     out  1      (macro only) set when lock is lost
//
// Output protocol:
//   CountValid is a valid-only strobe with no ready/back-pressure: EdgeCount
//   is stable from the cycle CountValid is high until the next CountValid, and
//   a consumer must capture it in the cycle CountValid is high if it needs
//   every window.
// -----------------------------------------------------------------------------
module hdmi_clock_monitor #(
  parameter int GATE_CYCLES  = 1000000,
  parameter int CNT_W        = 24,
  parameter int MIN_EDGES    = 1000,
  parameter int MAX_EDGES    = 2000,
  parameter int LOCK_WINDOWS = 4,
  parameter int LOSS_WINDOWS = 2
) (
  input  logic             InternalClock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             ExternalToggle,
  output logic [CNT_W-1:0] EdgeCount,
  output logic             CountValid,
  output logic             Locked,
  output logic [1:0]       State,
  output logic [1:0]       LED
`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
  ,
  input  logic             ClearLoss,
  output logic             LossSticky
`endif
);

  localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int RUN_MAX = (LOCK_WINDOWS > LOSS_WINDOWS) ? LOCK_WINDOWS : LOSS_WINDOWS;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_EDGES);
  localparam logic [RUN_W-1:0]  LOCK_C    = RUN_W'(LOCK_WINDOWS);
  localparam logic [RUN_W-1:0]  LOSS_C    = RUN_W'(LOSS_WINDOWS);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_NO_CLOCK = 2'd1,
    ST_ACQUIRE  = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  // Synchroniser chain and edge detect
  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic w_edge;

  // Gate window and edge counting
  logic [GATE_W-1:0] r_gate;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_sum;
  logic              w_run;
  logic              w_gate_end;
  logic              w_good;

  // FSM
  state_t           r_state;
  state_t           w_state_nxt;
  logic [RUN_W-1:0] r_good_run;
  logic [RUN_W-1:0] w_good_run_nxt;
  logic [RUN_W-1:0] r_bad_run;
  logic [RUN_W-1:0] w_bad_run_nxt;
  logic             r_led1;
  logic             w_led1_nxt;
  logic             r_locked;
  logic [RUN_W-1:0] w_good_inc;
  logic [RUN_W-1:0] w_bad_inc;

  logic [CNT_W-1:0] r_edge_count;
  logic             r_count_valid;

  // Any transition of the synchronised toggle is one edge of the divided clock.
  assign w_edge = r_sync2 ^ r_sync3;

  // Counting only runs outside IDLE; Enable is included directly so that a
  // falling Enable suppresses a window end in the same cycle.
  assign w_run      = Enable && (r_state != ST_IDLE);
  assign w_gate_end = w_run && (r_gate == GATE_LAST);

  // Count including this cycle's edge; saturates instead of wrapping.
  assign w_cnt_sum = (w_edge && (r_cnt != CNT_MAX)) ? (r_cnt + CNT_W'(1)) : r_cnt;
  assign w_good    = (w_cnt_sum >= MIN_C) && (w_cnt_sum <= MAX_C);

  assign w_good_inc = r_good_run + RUN_ONE;
  assign w_bad_inc  = r_bad_run + RUN_ONE;

  always_ff @(posedge InternalClock) begin
    if (Reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_gate        <= '0;
      r_cnt         <= '0;
      r_edge_count  <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_sync1       <= ExternalToggle;
      r_sync2       <= r_sync1;
      r_sync3       <= r_sync2;
      r_count_valid <= 1'b0;
      if (!w_run) begin
        r_gate <= '0;
        r_cnt  <= '0;
      end else if (w_gate_end) begin
        r_gate        <= '0;
        r_cnt         <= '0;
        r_edge_count  <= w_cnt_sum;
        r_count_valid <= 1'b1;
      end else begin
        r_gate <= r_gate + GATE_W'(1);
        r_cnt  <= w_cnt_sum;
      end
    end
  end

  // FSM state register
  always_ff @(posedge InternalClock) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_good_run <= '0;
      r_bad_run  <= '0;
      r_led1     <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_run <= w_good_run_nxt;
      r_bad_run  <= w_bad_run_nxt;
      r_led1     <= w_led1_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
    end
  end

  // FSM next-state logic; apart from IDLE entry/exit, moves only at window end.
  always_comb begin
    w_state_nxt    = r_state;
    w_good_run_nxt = r_good_run;
    w_bad_run_nxt  = r_bad_run;
    w_led1_nxt     = r_led1;
    if (!Enable) begin
      w_state_nxt    = ST_IDLE;
      w_good_run_nxt = '0;
      w_bad_run_nxt  = '0;
      w_led1_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt    = ST_NO_CLOCK;
          w_good_run_nxt = '0;
          w_bad_run_nxt  = '0;
          w_led1_nxt     = 1'b0;
        end
        ST_NO_CLOCK: begin
          if (w_gate_end && w_good) begin
            if (LOCK_WINDOWS == 1) begin
              w_state_nxt    = ST_LOCKED;
              w_good_run_nxt = '0;
              w_bad_run_nxt  = '0;
              w_led1_nxt     = 1'b1;
            end else begin
              w_state_nxt    = ST_ACQUIRE;
              w_good_run_nxt = RUN_ONE;
              w_led1_nxt     = 1'b0;
            end
          end
        end
        ST_ACQUIRE: begin
          if (w_gate_end) begin
            if (!w_good) begin
              w_state_nxt    = ST_NO_CLOCK;
              w_good_run_nxt = '0;
              w_led1_nxt     = 1'b0;
            end else if (w_good_inc == LOCK_C) begin
              w_state_nxt    = ST_LOCKED;
              w_good_run_nxt = '0;
              w_bad_run_nxt  = '0;
              w_led1_nxt     = 1'b1;
            end else begin
              // Still acquiring: blink once per window.
              w_good_run_nxt = w_good_inc;
              w_led1_nxt     = ~r_led1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_gate_end) begin
            if (w_good) begin
              w_bad_run_nxt = '0;
            end else if (w_bad_inc == LOSS_C) begin
              w_state_nxt   = ST_NO_CLOCK;
              w_bad_run_nxt = '0;
              w_led1_nxt    = 1'b0;
            end else begin
              w_bad_run_nxt = w_bad_inc;
            end
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_good_run_nxt = '0;
          w_bad_run_nxt  = '0;
          w_led1_nxt     = 1'b0;
        end
      endcase
    end
  end

`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
  logic r_loss_sticky;
  logic w_loss_event;

  // Only a genuine loss of lock sets the flag; Enable=0 leaves it untouched.
  assign w_loss_event = (r_state == ST_LOCKED) && (w_state_nxt == ST_NO_CLOCK);

  always_ff @(posedge InternalClock) begin
    if (Reset) begin
      r_loss_sticky <= 1'b0;
    end else if (w_loss_event) begin
      r_loss_sticky <= 1'b1;
    end else if (ClearLoss) begin
      r_loss_sticky <= 1'b0;
    end
  end

  assign LossSticky = r_loss_sticky;
`endif

  assign EdgeCount  = r_edge_count;
  assign CountValid = r_count_valid;
  assign Locked     = r_locked;
  assign State      = r_state;
  assign LED        = {r_led1, r_locked};

endmodule

// File: tb/tb_hdmi_clock_monitor.sv
module tb_hdmi_clock_monitor;

  localparam int GATE   = 100;
  localparam int CNT_W  = 24;
  localparam int SAT_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             ext_tog;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             locked;
  logic [1:0]       state;
  logic [1:0]       led;

  logic             sat_tog;
  logic [SAT_W-1:0] sat_edge_count;
  logic             sat_count_valid;
  logic             sat_locked;
  logic [1:0]       sat_state;
  logic [1:0]       sat_led;

`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
  logic clear_loss;
  logic loss_sticky;
  logic sat_loss_sticky;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  int tog_period = 0;
  int tog_cnt    = 0;

  hdmi_clock_monitor #(
    .GATE_CYCLES(GATE), .CNT_W(CNT_W), .MIN_EDGES(10), .MAX_EDGES(14),
    .LOCK_WINDOWS(3), .LOSS_WINDOWS(2)
  ) u_dut (
    .InternalClock (clk),
    .Reset         (rst),
    .Enable        (enable),
    .ExternalToggle(ext_tog),
    .EdgeCount     (edge_count),
    .CountValid    (count_valid),
    .Locked        (locked),
    .State         (state),
    .LED           (led)
`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
    ,
    .ClearLoss     (clear_loss),
    .LossSticky    (loss_sticky)
`endif
  );

  hdmi_clock_monitor #(
    .GATE_CYCLES(GATE), .CNT_W(SAT_W), .MIN_EDGES(10), .MAX_EDGES(14),
    .LOCK_WINDOWS(3), .LOSS_WINDOWS(2)
  ) u_sat (
    .InternalClock (clk),
    .Reset         (rst),
    .Enable        (1'b1),
    .ExternalToggle(sat_tog),
    .EdgeCount     (sat_edge_count),
    .CountValid    (sat_count_valid),
    .Locked        (sat_locked),
    .State         (sat_state),
    .LED           (sat_led)
`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
    ,
    .ClearLoss     (1'b0),
    .LossSticky    (sat_loss_sticky)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // HDMI-domain divider model: toggles every tog_period cycles (0 = stopped).
  initial begin
    ext_tog = 1'b0;
    forever begin
      @(negedge clk);
      if (tog_period != 0) begin
        tog_cnt = tog_cnt + 1;
        if (tog_cnt >= tog_period) begin
          tog_cnt = 0;
          ext_tog = ~ext_tog;
        end
      end
    end
  end

  // Fastest possible toggle for the saturation instance.
  initial begin
    sat_tog = 1'b0;
    forever begin
      @(negedge clk);
      sat_tog = ~sat_tog;
    end
  end

  // Bounded wait for the next CountValid; returns cycles waited.
  task automatic wait_cv(input string name, input int limit, output int cycles);
    cycles = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cycles++;
      if (count_valid) break;
      if (cycles >= limit) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no CountValid within %0d cycles", name, limit);
        break;
      end
    end
  endtask

  task automatic set_toggle(input int period);
    tog_cnt    = 0;
    tog_period = period;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b0;
`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
    clear_loss = 1'b0;
`endif
    set_toggle(8);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (edge_count !== '0) begin n_fail++; $display("FAIL reset_edge_count: got %0d want 0", edge_count); end
    n_cmp++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_count_valid: got %b want 0", count_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (led !== 2'b00) begin n_fail++; $display("FAIL reset_led: got %b want 00", led); end
`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
    n_cmp++; if (loss_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", loss_sticky); end
`endif
  endtask

  task automatic test_lock();
    int cyc;
    rst    = 1'b0;
    enable = 1'b1;
    wait_cv("lock_w1", 300, cyc);
    n_cmp++; if (cyc != 101) begin n_fail++; $display("FAIL lock_first_latency: got %0d want 101", cyc); end
    n_cmp++; if (edge_count != 12 && edge_count != 13) begin n_fail++; $display("FAIL lock_w1_count: got %0d want 12 or 13", edge_count); end
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL lock_w1_state: got %0d want 2", state); end
    n_cmp++; if (led[0] !== 1'b0) begin n_fail++; $display("FAIL lock_w1_led0: got %b want 0", led[0]); end
    wait_cv("lock_w2", 300, cyc);
    n_cmp++; if (cyc != 100) begin n_fail++; $display("FAIL lock_period: got %0d want 100", cyc); end
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL lock_w2_state: got %0d want 2", state); end
    wait_cv("lock_w3", 300, cyc);
    n_cmp++; if (edge_count != 12 && edge_count != 13) begin n_fail++; $display("FAIL lock_w3_count: got %0d want 12 or 13", edge_count); end
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL lock_w3_state: got %0d want 3", state); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_w3_locked: got %b want 1", locked); end
    n_cmp++; if (led !== 2'b11) begin n_fail++; $display("FAIL lock_w3_led: got %b want 11", led); end
    @(posedge clk);
    #1;
    n_cmp++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL lock_pulse_width: got %b want 0", count_valid); end
  endtask

  task automatic test_loss();
    int cyc;
    // Stop late in the window so this window is still good.
    repeat (95) @(posedge clk);
    #1;
    tog_period = 0;
    wait_cv("loss_wa", 300, cyc);
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL loss_wa_state: got %0d want 3", state); end
    wait_cv("loss_wb", 300, cyc);
    n_cmp++; if (edge_count !== '0) begin n_fail++; $display("FAIL loss_wb_count: got %0d want 0", edge_count); end
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL loss_wb_state: got %0d want 3", state); end
    wait_cv("loss_wc", 300, cyc);
    n_cmp++; if (edge_count !== '0) begin n_fail++; $display("FAIL loss_wc_count: got %0d want 0", edge_count); end
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL loss_wc_state: got %0d want 1", state); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_wc_locked: got %b want 0", locked); end
    n_cmp++; if (led !== 2'b00) begin n_fail++; $display("FAIL loss_wc_led: got %b want 00", led); end
`ifdef HDMI_CLOCK_MONITOR_STICKY_EN
    n_cmp++; if (loss_sticky !== 1'b1) begin n_fail++; $display("FAIL loss_sticky_set: got %b want 1", loss_sticky); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (loss_sticky !== 1'b1) begin n_fail++; $display("FAIL loss_sticky_hold: got %b want 1", loss_sticky); end
    clear_loss = 1'b1;
    @(posedge clk);
    #1;
    clear_loss = 1'b0;
    n_cmp++; if (loss_sticky !== 1'b0) begin n_fail++; $display("FAIL loss_sticky_clear: got %b want 0", loss_sticky); end
`endif
  endtask

  task automatic test_fast();
    int cyc;
    set_toggle(4);
    wait_cv("fast_skip", 300, cyc);
    for (int i = 0; i < 2; i++) begin
      wait_cv("fast_w", 300, cyc);
      n_cmp++; if (edge_count !== 25) begin n_fail++; $display("FAIL fast_count[%0d]: got %0d want 25", i, edge_count); end
      n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL fast_state[%0d]: got %0d want 1", i, state); end
      n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL fast_locked[%0d]: got %b want 0", i, locked); end
    end
  endtask

  task automatic test_glitch();
    int cyc;
    set_toggle(8);
    for (int i = 0; i < 6; i++) begin
      wait_cv("glitch_relock", 300, cyc);
      if (state == 2'd3) break;
    end
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL glitch_relock_state: got %0d want 3", state); end
    // One sparse window (3-4 edges) while locked.
    set_toggle(25);
    wait_cv("glitch_bad", 300, cyc);
    n_cmp++; if (edge_count < 3 || edge_count > 4) begin n_fail++; $display("FAIL glitch_bad_count: got %0d want 3..4", edge_count); end
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL glitch_bad_state: got %0d want 3", state); end
    set_toggle(8);
    for (int i = 0; i < 2; i++) begin
      wait_cv("glitch_good", 300, cyc);
      n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL glitch_good_state[%0d]: got %0d want 3", i, state); end
      n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL glitch_good_locked[%0d]: got %b want 1", i, locked); end
    end
  endtask

  task automatic test_enable();
    int cyc;
    int seen;
    logic [CNT_W-1:0] held;
    repeat (50) @(posedge clk);
    #1;
    held   = edge_count;
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL en_off_state: got %0d want 0", state); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL en_off_locked: got %b want 0", locked); end
    n_cmp++; if (led !== 2'b00) begin n_fail++; $display("FAIL en_off_led: got %b want 00", led); end
    n_cmp++; if (edge_count !== held) begin n_fail++; $display("FAIL en_off_hold: got %0d want %0d", edge_count, held); end
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (count_valid) seen++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL en_off_no_valid: got %0d pulses want 0", seen); end
    enable = 1'b1;
    wait_cv("en_on", 300, cyc);
    n_cmp++; if (cyc != 101) begin n_fail++; $display("FAIL en_on_latency: got %0d want 101", cyc); end
    n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL en_on_state: got %0d want 2", state); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (edge_count !== '0) begin n_fail++; $display("FAIL rmid_edge_count: got %0d want 0", edge_count); end
    n_cmp++; if (count_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_count_valid: got %b want 0", count_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmid_locked: got %b want 0", locked); end
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d want 0", state); end
    n_cmp++; if (led !== 2'b00) begin n_fail++; $display("FAIL rmid_led: got %b want 00", led); end
    // The aborted window is not reported; the fresh one ends after IDLE + 100.
    wait_cv("rmid_restart", 300, cyc);
    n_cmp++; if (cyc != 101) begin n_fail++; $display("FAIL rmid_restart_latency: got %0d want 101", cyc); end
  endtask

  task automatic test_saturate();
    int cyc;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sat_count_valid) break;
      if (cyc >= 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sat_wait: no CountValid within 300 cycles");
        break;
      end
    end
    n_cmp++; if (sat_edge_count !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d want 15", sat_edge_count); end
    n_cmp++; if (sat_state !== 2'd1) begin n_fail++; $display("FAIL sat_state: got %0d want 1", sat_state); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_loss();
    test_fast();
    test_glitch();
    test_enable();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
